bcd_display_scan: RTL and testbench

//  Time-multiplexed seven-segment driver for packed-BCD numbers coming from the binary-to-BCD

---
 rtl/bcd_display_scan.sv | 128 ++++++++++++
 tb/tb_bcd_display_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Time-multiplexed seven-segment scanner for packed BCD. It keeps a shadow copy of the number,
// scans one digit per refresh slot, and supports dead time and leading-zero blanking.
module bcd_display_scan #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int DEAD_CYCLES = 8,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   bcd,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  frame_tick
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  DEAD_LIM = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW != 0}};
   localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW != 0}};

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                frame_tick_q, frame_tick_d;

   logic [3:0]          digit [DIGITS];
   logic [DIGITS-1:0]   upper_nz;
   logic [DIGITS-1:0]   blank_vec;

   // upper_nz[i]: some shadow digit at position i or above is nonzero (A-F included).
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign digit[gi] = shadow_q[4*gi +: 4];
         if (gi == DIGITS - 1) begin : g_top
            assign upper_nz[gi] = (digit[gi] != 4'd0);
         end else begin : g_lower
            assign upper_nz[gi] = (digit[gi] != 4'd0) || upper_nz[gi+1];
         end
         if (gi == 0) begin : g_ones
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = blank_lz && !upper_nz[gi];
         end
      end
   endgenerate

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   logic                slot_end;
   logic [DIGITS-1:0]   an_act;
   logic [6:0]          seg_act;

   always_comb begin
      slot_end     = (cnt_q == CNT_LAST);
      cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      frame_tick_d = slot_end && (idx_q == IDX_LAST);
      shadow_d     = load ? bcd : shadow_q;

      an_act         = '0;
      an_act[idx_q]  = 1'b1;
      seg_act        = seg_decode(digit[idx_q]);

      // Dead time and blanked digits both drive every pin inactive.
      if ((cnt_q < DEAD_LIM) || blank_vec[idx_q]) begin
         an_d  = AN_OFF;
         seg_d = SEG_OFF;
      end else if (ACTIVE_LOW != 0) begin
         an_d  = ~an_act;
         seg_d = ~seg_act;
      end else begin
         an_d  = an_act;
         seg_d = seg_act;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         an_q         <= AN_OFF;
         seg_q        <= SEG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan: 4 digits, 4-cycle slots, 1 dead cycle, active-low pins.
module tb_bcd_display_scan;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bcd = 16'h0000;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        frame_tick;

   int vectors = 0;
   int miscompares = 0;
   bit mon_en = 1'b0;

   bcd_display_scan #(
      .DIGITS      (4),
      .REFRESH_DIV (4),
      .DEAD_CYCLES (1),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bcd        (bcd),
      .load       (load),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // At most one anode may ever be active (active-low: at most one zero bit).
   always @(negedge clk) begin
      if (mon_en) check("onehot", 32'($countones(~an) <= 1), 32'd1);
   end

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      load  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_an",  32'(an),  32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_ft",  32'(frame_tick), 32'd0);
   endtask

   // Release reset while loading; returns at the dead cycle of slot 0.
   task automatic start_case(input logic [15:0] v, input logic blz);
      reset    = 1'b0;
      load     = 1'b1;
      bcd      = v;
      blank_lz = blz;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Called at a slot-0 dead cycle; walks one full frame and returns at the next one.
   task automatic scan_frame(input string tag, input logic [15:0] ean, input logic [27:0] eseg);
      for (int s = 0; s < 4; s++) begin
         check($sformatf("%s_dead%0d_an", tag, s),  32'(an),  32'hF);
         check($sformatf("%s_dead%0d_seg", tag, s), 32'(seg), 32'h7F);
         check($sformatf("%s_dead%0d_ft", tag, s),  32'(frame_tick), 32'd0);
         for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("%s_s%0dc%0d_an", tag, s, c),  32'(an),  32'(ean[s*4 +: 4]));
            check($sformatf("%s_s%0dc%0d_seg", tag, s, c), 32'(seg), 32'(eseg[s*7 +: 7]));
            check($sformatf("%s_s%0dc%0d_ft", tag, s, c),  32'(frame_tick),
                  32'((s == 3) && (c == 3)));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      mon_en = 1'b1;

      start_case(16'h1234, 1'b0);
      scan_frame("1234a", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});
      scan_frame("1234b", 16'h7BDE, {7'h79, 7'h24, 7'h30, 7'h19});

      do_reset();
      start_case(16'h0007, 1'b1);
      scan_frame("0007lz", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h78});

      do_reset();
      start_case(16'h0007, 1'b0);
      scan_frame("0007", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h78});

      do_reset();
      start_case(16'h0000, 1'b1);
      scan_frame("0000lz", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40});

      do_reset();
      start_case(16'h0A00, 1'b1);
      scan_frame("0A00lz", 16'hFBDE, {7'h7F, 7'h3F, 7'h40, 7'h40});

      do_reset();
      start_case(16'h9F85, 1'b0);
      scan_frame("9F85", 16'h7BDE, {7'h10, 7'h3F, 7'h00, 7'h12});

      // Load mid-slot: one more cycle of the old digit, then the new one.
      do_reset();
      start_case(16'h1234, 1'b0);
      @(negedge clk);
      check("ml_pre_an",  32'(an),  32'hE);
      check("ml_pre_seg", 32'(seg), 32'h19);
      load = 1'b1;
      bcd  = 16'h0009;
      @(negedge clk);
      load = 1'b0;
      check("ml_old_seg", 32'(seg), 32'h19);
      @(negedge clk);
      check("ml_new_an",  32'(an),  32'hE);
      check("ml_new_seg", 32'(seg), 32'h10);
      @(negedge clk);
      check("ml_dead_an", 32'(an),  32'hF);
      @(negedge clk);
      check("ml_d1_an",   32'(an),  32'hD);
      check("ml_d1_seg",  32'(seg), 32'h40);

      // Reset mid-scan: outputs drop at once, scan restarts at digit 0 with shadow cleared.
      reset = 1'b1;
      @(negedge clk);
      check("mr_an",  32'(an),  32'hF);
      check("mr_seg", 32'(seg), 32'h7F);
      check("mr_ft",  32'(frame_tick), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      scan_frame("postrst", 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h40});

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
